uart_protocol_tx: RTL and testbench

//  Frame transmitter for the host<->FPGA image/label UART link. Takes one image,

---
 rtl/uart_protocol_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_protocol_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_protocol_tx.sv
// -----------------------------------------------------------------------------
// uart_protocol_tx
//
// Frame transmitter for the host<->FPGA image/label UART link. One accepted
// send emits the byte stream
//   START(8'hFF), mode(8'hF0 train / 8'h0F test), image bytes (byte 0 first),
//   label, checksum, STOP(8'hBB)
// to a UART byte serializer over a valid/ready handshake.
//
// The checksum is an 8-bit one's-complement (end-around carry) sum over the
// image bytes and the label.
//
// Optional feature, enabled by defining UART_PROTO_TX_RESEND_EN:
//   resend_req retransmits the latched frame once per frame, either while busy
//   or within RESEND_WIN cycles after done. Without the macro resend_req is
//   ignored.
//
// Parameters
//   IMG_SZ      image width in bits (multiple of 8, max 8*65535)
//   RESEND_WIN  cycles after done during which resend_req is honoured
//
// Ports
//   uart_sampling_clk  clock
//   rst                asynchronous active-high reset
//   send               1-cycle frame request, accepted only when idle
//   train              1 = TRAIN frame, 0 = TEST frame
//   label   [7:0]      label byte
//   image   [IMG_SZ]   pixel data, byte k = image[8k+7:8k]
//   resend_req         1-cycle retransmit request
//   tx_ready           byte sink can accept tx_byte
//   tx_valid           tx_byte valid (registered)
//   tx_byte [7:0]      byte to transmit (registered)
//   busy               frame in progress
//   done               1-cycle pulse after the STOP byte transfers
// -----------------------------------------------------------------------------
module uart_protocol_tx #(
  parameter int IMG_SZ     = 784 << 3,
  parameter int RESEND_WIN = 1024
) (
  input  logic              uart_sampling_clk,
  input  logic              rst,
  input  logic              send,
  input  logic              train,
  input  logic [7:0]        label,
  input  logic [IMG_SZ-1:0] image,
  input  logic              resend_req,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_byte,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = IMG_SZ / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  localparam logic [7:0] START_BYTE = 8'hFF;
  localparam logic [7:0] STOP_BYTE  = 8'hBB;
  localparam logic [7:0] MODE_TRAIN = 8'hF0;
  localparam logic [7:0] MODE_TEST  = 8'h0F;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_MODE, S_DATA, S_LABEL, S_CHECK, S_STOP
  } state_t;

  // One's-complement add: fold the carry out of bit 7 back into bit 0.
  function automatic logic [7:0] oc_add(input logic [7:0] c, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, b};
    return s[7:0] + {7'b0, s[8]};
  endfunction

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic [7:0]      csum, csum_n;
  logic            tx_valid_n;
  logic [7:0]      tx_byte_n;
  logic            done_n;
  logic            latch;
  logic            xfer;

  // Latched frame copy, viewed as an array of bytes.
  logic [NBYTES-1:0][7:0] img_q;
  logic [7:0]             label_q;
  logic                   train_q;

`ifdef UART_PROTO_TX_RESEND_EN
  localparam int WW = $clog2(RESEND_WIN + 1);
  logic [WW-1:0] win, win_n;
  logic          resent, resent_n;
  logic          pend, pend_n;
  logic          honour;
  logic          restart;
`else
  logic          unused_resend;
  assign unused_resend = resend_req;
`endif

  assign xfer = tx_valid && tx_ready;
  assign busy = (state != S_IDLE);

  // NOTE: every variable is given a default first so no path leaves one
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    state_n    = state;
    count_n    = count;
    csum_n     = csum;
    tx_valid_n = tx_valid;
    tx_byte_n  = tx_byte;
    done_n     = 1'b0;
    latch      = 1'b0;

    case (state)
      S_IDLE: begin
        csum_n  = 8'h00;
        count_n = '0;
        if (send) begin
          latch      = 1'b1;
          state_n    = S_START;
          tx_valid_n = 1'b1;
          tx_byte_n  = START_BYTE;
        end
      end
      S_START: if (xfer) begin
        state_n   = S_MODE;
        tx_byte_n = train_q ? MODE_TRAIN : MODE_TEST;
      end
      S_MODE: if (xfer) begin
        state_n   = S_DATA;
        count_n   = '0;
        tx_byte_n = img_q[0];
      end
      S_DATA: if (xfer) begin
        csum_n = oc_add(csum, tx_byte);
        if (count == LAST_IDX) begin
          state_n   = S_LABEL;
          tx_byte_n = label_q;
        end else begin
          count_n   = count + 1'b1;
          tx_byte_n = img_q[count + 1'b1];
        end
      end
      S_LABEL: if (xfer) begin
        // The checksum byte must already include the label being sent now.
        csum_n    = oc_add(csum, tx_byte);
        state_n   = S_CHECK;
        tx_byte_n = csum_n;
      end
      S_CHECK: if (xfer) begin
        state_n   = S_STOP;
        tx_byte_n = STOP_BYTE;
      end
      S_STOP: if (xfer) begin
        state_n    = S_IDLE;
        tx_valid_n = 1'b0;
        tx_byte_n  = 8'h00;
        done_n     = 1'b1;
      end
      default: begin
        state_n    = S_IDLE;
        tx_valid_n = 1'b0;
      end
    endcase

`ifdef UART_PROTO_TX_RESEND_EN
    win_n    = win;
    resent_n = resent;
    pend_n   = pend;
    restart  = 1'b0;

    if (state == S_IDLE && win != '0) win_n = win - 1'b1;
    if (done_n)                       win_n = WW'(RESEND_WIN);

    honour = resend_req && !resent && ((state != S_IDLE) || (win != '0));

    if (honour) begin
      resent_n = 1'b1;
      latch    = 1'b0;  // resend wins over a simultaneous send
      if (state == S_IDLE || xfer) restart = 1'b1;
      else                         pend_n  = 1'b1;  // let the held byte go first
    end

    if (pend && xfer) begin
      restart = 1'b1;
      pend_n  = 1'b0;
    end

    if (restart) begin
      state_n    = S_START;
      tx_valid_n = 1'b1;
      tx_byte_n  = START_BYTE;
      csum_n     = 8'h00;
      count_n    = '0;
      win_n      = '0;
    end

    if (latch) resent_n = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      csum     <= 8'h00;
      tx_valid <= 1'b0;
      tx_byte  <= 8'h00;
      done     <= 1'b0;
`ifdef UART_PROTO_TX_RESEND_EN
      win      <= '0;
      resent   <= 1'b0;
      pend     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      count    <= count_n;
      csum     <= csum_n;
      tx_valid <= tx_valid_n;
      tx_byte  <= tx_byte_n;
      done     <= done_n;
`ifdef UART_PROTO_TX_RESEND_EN
      win      <= win_n;
      resent   <= resent_n;
      pend     <= pend_n;
`endif
    end
  end

  // NOTE: the frame copy is pure data, only read after a send has loaded it,
  // so it carries no reset and the wide register stays a plain enable flop.
  always_ff @(posedge uart_sampling_clk) begin
    if (latch) begin
      img_q   <= image;
      label_q <= label;
      train_q <= train;
    end
  end

endmodule

// File: tb/tb_uart_protocol_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_protocol_tx
//
// Self-checking bench for uart_protocol_tx with IMG_SZ=32. Frames are described
// in a vector table; expected bytes go into a scoreboard queue when a frame is
// requested and are popped by a monitor on every handshake. Hand-written
// sequences cover backpressure, send while busy, reset mid-frame and resend.
// -----------------------------------------------------------------------------
module tb_uart_protocol_tx;

  localparam int IMG_SZ = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              send;
  logic              train;
  logic [7:0]        label;
  logic [IMG_SZ-1:0] image;
  logic              resend_req;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_byte;
  logic              busy;
  logic              done;

  uart_protocol_tx #(.IMG_SZ(IMG_SZ), .RESEND_WIN(1024)) dut (
    .uart_sampling_clk(clk),
    .rst              (rst),
    .send             (send),
    .train            (train),
    .label            (label),
    .image            (image),
    .resend_req       (resend_req),
    .tx_ready         (tx_ready),
    .tx_valid         (tx_valid),
    .tx_byte          (tx_byte),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        train;
    logic [31:0] image;
    logic [7:0]  label;
    logic [7:0]  csum;
  } vec_t;

  vec_t       vecs[3];
  logic [7:0] sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  bit         hold_pending = 0;
  logic [7:0] held_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: handshakes are sampled on the falling edge, they complete on the
  // following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", tx_valid, 1);
        check("hold_byte", tx_byte, held_byte);
      end
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte actual=%0h expected=none", tx_byte);
        end else begin
          check("byte", tx_byte, sb.pop_front());
        end
        xfer_cnt++;
      end
      hold_pending = tx_valid && !tx_ready;
      held_byte    = tx_byte;
      if (done) done_cnt++;
    end
  end

  task automatic push_frame(input vec_t v);
    sb.push_back(8'hFF);
    sb.push_back(v.train ? 8'hF0 : 8'h0F);
    for (int k = 0; k < 4; k++) sb.push_back(v.image[8*k +: 8]);
    sb.push_back(v.label);
    sb.push_back(v.csum);
    sb.push_back(8'hBB);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic start_frame(input vec_t v);
    push_frame(v);
    xfer_cnt = 0;
    train = v.train;
    image = v.image;
    label = v.label;
    send  = 1'b1;
    @(posedge clk); #1;
    send  = 1'b0;
    image = '0;
    label = 8'h00;
    train = ~v.train;
  endtask

  // Runs until done with an optional stall pattern (5 low cycles at START,
  // DATA byte 2 and CHECK) and an optional send poke while busy.
  task automatic wait_frame(input bit bp, input int poke, input logic [31:0] poke_img,
                            input int exp_cyc, input string name);
    int cyc, stall, last_idx, d0;
    bit seen;
    cyc = 0; stall = 0; last_idx = -1; seen = 0; d0 = done_cnt;
    while (!seen && cyc < 200) begin
      if (bp) begin
        if (xfer_cnt != last_idx) begin
          stall    = 0;
          last_idx = xfer_cnt;
        end
        if ((xfer_cnt == 0 || xfer_cnt == 4 || xfer_cnt == 7) && stall < 5) begin
          tx_ready = 1'b0;
          stall++;
        end else begin
          tx_ready = 1'b1;
        end
      end else begin
        tx_ready = 1'b1;
      end
      if (poke >= 0) begin
        send = (cyc == poke);
        if (cyc == poke) begin
          image = poke_img;
          label = 8'hEE;
          train = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1;
        check({name, "_busy_at_done"}, busy, 0);
      end
      @(posedge clk); #1;
    end
    send     = 1'b0;
    tx_ready = 1'b1;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end else begin
      check({name, "_cycles"}, cyc, exp_cyc);
    end
    @(negedge clk);
    check({name, "_done_pulse_len"}, done, 0);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Counts cycles showing any activity; expects none.
  task automatic idle_watch(input int n, input string name);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_valid || busy) act++;
    end
    check({name, "_activity"}, act, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // TEST 04030201/07: 01+02+03+04+07 = 11
    vecs[0] = '{train: 1'b0, image: 32'h04030201, label: 8'h07, csum: 8'h11};
    // TRAIN all-ones/01: FF repeatedly folds to FF, FF+01 = 100 -> 01
    vecs[1] = '{train: 1'b1, image: 32'hFFFFFFFF, label: 8'h01, csum: 8'h01};
    // TEST F0,10,7F,80 / 55: F0+10->01, +7F->80, +80->01, +55->56
    vecs[2] = '{train: 1'b0, image: 32'h807F10F0, label: 8'h55, csum: 8'h56};

    rst = 1'b1; send = 1'b0; train = 1'b0; label = 8'h00; image = '0;
    resend_req = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      start_frame(vecs[i]);
      wait_frame(0, -1, '0, 10, $sformatf("vec%0d", i));
    end

    // Backpressure: three 5-cycle stalls add 15 cycles.
    start_frame(vecs[0]);
    wait_frame(1, -1, '0, 25, "backpressure");

    // send while busy is ignored; no second frame follows.
    start_frame(vecs[1]);
    wait_frame(0, 4, 32'hDEADBEEF, 10, "send_busy");
    idle_watch(15, "send_busy_after");

    // Reset in S_DATA aborts at once.
    start_frame(vecs[2]);
    for (int i = 0; i < 50 && xfer_cnt < 3; i++) begin
      @(posedge clk); #1;
    end
    check("abort_in_data", xfer_cnt, 3);
    rst = 1'b1;
    #1;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    idle_watch(5, "abort_after");
    start_frame(vecs[0]);
    wait_frame(0, -1, '0, 10, "post_abort");

    // resend_req about 10 cycles after done.
    repeat (8) @(posedge clk);
    #1;
`ifdef UART_PROTO_TX_RESEND_EN
    push_frame(vecs[0]);
    xfer_cnt = 0;
    resend_req = 1'b1;
    @(posedge clk); #1;
    resend_req = 1'b0;
    wait_frame(0, -1, '0, 10, "resend");
    repeat (5) @(posedge clk);
    #1;
    resend_req = 1'b1;
    @(posedge clk); #1;
    resend_req = 1'b0;
    idle_watch(20, "second_resend");
`else
    resend_req = 1'b1;
    @(posedge clk); #1;
    resend_req = 1'b0;
    idle_watch(20, "resend_disabled");
`endif

    check("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
